// File: rtl/ct_mmu_sysmap_pkg.sv
// Shared types and constants for the MMU sysmap attribute lookup.
package ct_mmu_sysmap_pkg;

  localparam int SYSMAP_REGION_NUM = 8;
  localparam int SYSMAP_ADDR_W     = 28;
  localparam int SYSMAP_ATTR_W     = 5;

  localparam logic [SYSMAP_ATTR_W-1:0] SYSMAP_DFLT_ATTR = 5'b01111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } sysmap_state_t;

endpackage

// File: rtl/ct_mmu_sysmap_cmp.sv
// Shared region comparator: upper-bound magnitude compare combined with the
// lower-bound flag carried over from the previous region.
module ct_mmu_sysmap_cmp
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int ADDR_W = SYSMAP_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] upaddr,
  input  logic              ge_bottom,
  output logic              ls_top,
  output logic              hit
);

  assign ls_top = addr < upaddr;
  assign hit    = ge_bottom && ls_top;

endmodule

// File: rtl/ct_mmu_sysmap_scan_ctrl.sv
// Sysmap lookup controller: round-robin DTLB/ITLB grant, one region per cycle scan, one-cycle response.
// Optional feature macro MMU_SYSMAP_LAST_HIT_EN adds a one-entry last-result cache that bypasses the scan.
module ct_mmu_sysmap_scan_ctrl
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int REGION_NUM = SYSMAP_REGION_NUM,
  parameter int ADDR_W     = SYSMAP_ADDR_W,
  parameter int ATTR_W     = SYSMAP_ATTR_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              dtlb_sysmap_req_vld,
  input  logic [ADDR_W-1:0] dtlb_sysmap_req_addr,
  output logic              sysmap_dtlb_req_rdy,
  input  logic              itlb_sysmap_req_vld,
  input  logic [ADDR_W-1:0] itlb_sysmap_req_addr,
  output logic              sysmap_itlb_req_rdy,
  output logic              sysmap_rsp_vld,
  output logic              sysmap_rsp_id,
  output logic [3:0]        sysmap_rsp_region,
  output logic [ATTR_W-1:0] sysmap_rsp_attr,
  input  logic              cp0_sysmap_wen,
  input  logic [2:0]        cp0_sysmap_idx,
  input  logic [ADDR_W-1:0] cp0_sysmap_upaddr,
  input  logic [ATTR_W-1:0] cp0_sysmap_attr
);

  localparam int                IDX_W       = $clog2(REGION_NUM);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(REGION_NUM - 1);
  localparam logic [3:0]        MISS_REGION = 4'(REGION_NUM);
  localparam logic [ATTR_W-1:0] DFLT_ATTR   = ATTR_W'(SYSMAP_DFLT_ATTR);

  logic [ADDR_W-1:0] upaddr_q [REGION_NUM];
  logic [ATTR_W-1:0] attr_q   [REGION_NUM];

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        upaddr_q[i] <= '0;
        attr_q[i]   <= DFLT_ATTR;
      end
    end else if (cp0_sysmap_wen) begin
      upaddr_q[cp0_sysmap_idx] <= cp0_sysmap_upaddr;
      attr_q[cp0_sysmap_idx]   <= cp0_sysmap_attr;
    end
  end

  sysmap_state_t     state, state_nxt;
  logic              rr_ptr;
  logic              in_idle, grant_d, grant_i, accept, acc_id;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              req_id;
  logic [IDX_W-1:0]  scan_idx;
  logic              ge_prev, ge_bottom, ls_top, hit, scan_last;
  logic              cache_hit;
  logic [3:0]        cache_region;
  logic [ATTR_W-1:0] cache_attr;

  // Pointer only breaks ties; a lone requester always wins.
  assign in_idle  = (state == IDLE) && !cpurst;
  assign grant_d  = in_idle && dtlb_sysmap_req_vld && (!itlb_sysmap_req_vld || !rr_ptr);
  assign grant_i  = in_idle && itlb_sysmap_req_vld && (!dtlb_sysmap_req_vld || rr_ptr);
  assign accept   = grant_d || grant_i;
  assign acc_id   = grant_i;
  assign acc_addr = grant_i ? itlb_sysmap_req_addr : dtlb_sysmap_req_addr;

  assign sysmap_dtlb_req_rdy = grant_d;
  assign sysmap_itlb_req_rdy = grant_i;
  assign sysmap_rsp_vld      = (state == RESP) && !cpurst;

  assign ge_bottom = (scan_idx == '0) ? 1'b1 : ge_prev;
  assign scan_last = (scan_idx == LAST_IDX);

  ct_mmu_sysmap_cmp #(.ADDR_W(ADDR_W)) u_cmp (
    .addr      (req_addr),
    .upaddr    (upaddr_q[scan_idx]),
    .ge_bottom (ge_bottom),
    .ls_top    (ls_top),
    .hit       (hit)
  );

`ifdef MMU_SYSMAP_LAST_HIT_EN
  logic              cache_vld;
  logic [ADDR_W-1:0] cache_addr;

  // A write in the acceptance cycle must be seen, so it also blocks a cache hit.
  assign cache_hit = cache_vld && !cp0_sysmap_wen && (acc_addr == cache_addr);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || cp0_sysmap_wen) begin
      cache_vld <= 1'b0;
    end else if (state == RESP) begin
      cache_vld    <= 1'b1;
      cache_addr   <= req_addr;
      cache_region <= sysmap_rsp_region;
      cache_attr   <= sysmap_rsp_attr;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_region = MISS_REGION;
  assign cache_attr   = DFLT_ATTR;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cache_hit ? RESP : SCAN;
      SCAN:    if (!cp0_sysmap_wen && (hit || scan_last)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state             <= IDLE;
      rr_ptr            <= 1'b0;
      req_addr          <= '0;
      req_id            <= 1'b0;
      scan_idx          <= '0;
      ge_prev           <= 1'b0;
      sysmap_rsp_id     <= 1'b0;
      sysmap_rsp_region <= '0;
      sysmap_rsp_attr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr   <= ~rr_ptr;
        req_addr <= acc_addr;
        req_id   <= acc_id;
        scan_idx <= '0;
        if (cache_hit) begin
          sysmap_rsp_id     <= acc_id;
          sysmap_rsp_region <= cache_region;
          sysmap_rsp_attr   <= cache_attr;
        end
      end
      if (state == SCAN) begin
        // A table update mid-scan restarts from region 0 so the result reflects the new table.
        if (cp0_sysmap_wen) begin
          scan_idx <= '0;
        end else begin
          ge_prev  <= !ls_top;
          scan_idx <= scan_idx + IDX_W'(1);
          if (hit) begin
            sysmap_rsp_id     <= req_id;
            sysmap_rsp_region <= 4'(scan_idx);
            sysmap_rsp_attr   <= attr_q[scan_idx];
          end else if (scan_last) begin
            sysmap_rsp_id     <= req_id;
            sysmap_rsp_region <= MISS_REGION;
            sysmap_rsp_attr   <= DFLT_ATTR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ct_mmu_sysmap_scan_ctrl.sv
// Directed and randomized lookups checked against an interval-table reference model.
module tb_ct_mmu_sysmap_scan_ctrl;

  localparam logic [4:0] DFLT = 5'b01111;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        dtlb_sysmap_req_vld;
  logic [27:0] dtlb_sysmap_req_addr;
  logic        sysmap_dtlb_req_rdy;
  logic        itlb_sysmap_req_vld;
  logic [27:0] itlb_sysmap_req_addr;
  logic        sysmap_itlb_req_rdy;
  logic        sysmap_rsp_vld;
  logic        sysmap_rsp_id;
  logic [3:0]  sysmap_rsp_region;
  logic [4:0]  sysmap_rsp_attr;
  logic        cp0_sysmap_wen;
  logic [2:0]  cp0_sysmap_idx;
  logic [27:0] cp0_sysmap_upaddr;
  logic [4:0]  cp0_sysmap_attr;

  ct_mmu_sysmap_scan_ctrl dut (
    .forever_cpuclk       (forever_cpuclk),
    .cpurst               (cpurst),
    .dtlb_sysmap_req_vld  (dtlb_sysmap_req_vld),
    .dtlb_sysmap_req_addr (dtlb_sysmap_req_addr),
    .sysmap_dtlb_req_rdy  (sysmap_dtlb_req_rdy),
    .itlb_sysmap_req_vld  (itlb_sysmap_req_vld),
    .itlb_sysmap_req_addr (itlb_sysmap_req_addr),
    .sysmap_itlb_req_rdy  (sysmap_itlb_req_rdy),
    .sysmap_rsp_vld       (sysmap_rsp_vld),
    .sysmap_rsp_id        (sysmap_rsp_id),
    .sysmap_rsp_region    (sysmap_rsp_region),
    .sysmap_rsp_attr      (sysmap_rsp_attr),
    .cp0_sysmap_wen       (cp0_sysmap_wen),
    .cp0_sysmap_idx       (cp0_sysmap_idx),
    .cp0_sysmap_upaddr    (cp0_sysmap_upaddr),
    .cp0_sysmap_attr      (cp0_sysmap_attr)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  int vecs = 0;
  int errs = 0;

  // Reference state: region table, round-robin pointer, last-result cache.
  logic [27:0] mup   [8];
  logic [4:0]  mattr [8];
  bit          m_ptr;
  bit          mc_vld;
  logic [27:0] mc_addr;
  int          mc_reg;
  logic [4:0]  mc_attr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Region i covers [upper bound of region i-1, upper bound of region i); first match wins.
  function automatic void ref_lookup(input logic [27:0] a, output int r, output logic [4:0] at);
    bit above;
    above = 1'b1;
    r = 8;
    at = DFLT;
    for (int i = 0; i < 8; i++) begin
      if (r == 8 && above && a < mup[i]) begin
        r = i;
        at = mattr[i];
      end
      above = (a >= mup[i]);
    end
  endfunction

  function automatic int base_lat(input int r);
    return (r == 8) ? 9 : r + 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mup[i] = '0;
      mattr[i] = DFLT;
    end
    m_ptr = 1'b0;
    mc_vld = 1'b0;
  endtask

  task automatic apply_wr(input int idx, input logic [27:0] up, input logic [4:0] at);
    cp0_sysmap_wen = 1'b1;
    cp0_sysmap_idx = 3'(idx);
    cp0_sysmap_upaddr = up;
    cp0_sysmap_attr = at;
    mup[idx] = up;
    mattr[idx] = at;
    mc_vld = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [27:0] up, input logic [4:0] at);
    @(negedge forever_cpuclk);
    apply_wr(idx, up, at);
    @(negedge forever_cpuclk);
    cp0_sysmap_wen = 1'b0;
  endtask

  // One lookup; wr_at = cycle offset of an optional table write (0 = acceptance cycle, <0 = none).
  task automatic run_req(input bit dv, input bit iv, input logic [27:0] da, input logic [27:0] ia,
                         input int wr_at, input int w_idx, input logic [27:0] w_up, input logic [4:0] w_at);
    bit          gid, got, resp_wr;
    logic [27:0] a;
    int          e_reg, e_lat, lat;
    logic [4:0]  e_at;
    @(negedge forever_cpuclk);
    cp0_sysmap_wen = 1'b0;
    dtlb_sysmap_req_vld = dv;
    itlb_sysmap_req_vld = iv;
    dtlb_sysmap_req_addr = da;
    itlb_sysmap_req_addr = ia;
    if (wr_at == 0) apply_wr(w_idx, w_up, w_at);
    #1;
    gid = (dv && iv) ? m_ptr : iv;
    chk("rdy_dtlb", sysmap_dtlb_req_rdy, dv && !gid);
    chk("rdy_itlb", sysmap_itlb_req_rdy, iv && gid);
    m_ptr = !m_ptr;
    a = gid ? ia : da;
    ref_lookup(a, e_reg, e_at);
    e_lat = base_lat(e_reg);
`ifdef MMU_SYSMAP_LAST_HIT_EN
    if (mc_vld && mc_addr == a) begin
      e_reg = mc_reg;
      e_at = mc_attr;
      e_lat = 1;
    end
`endif
    got = 1'b0;
    lat = 0;
    resp_wr = 1'b0;
    for (int k = 1; k <= 24 && !got; k++) begin
      @(negedge forever_cpuclk);
      cp0_sysmap_wen = 1'b0;
      if (k == wr_at) begin
        apply_wr(w_idx, w_up, w_at);
        if (k < e_lat) begin
          ref_lookup(a, e_reg, e_at);
          e_lat = k + base_lat(e_reg);
        end else begin
          resp_wr = 1'b1;
        end
      end
      #1;
      chk("rdy_busy", {sysmap_dtlb_req_rdy, sysmap_itlb_req_rdy}, 32'd0);
      if (sysmap_rsp_vld) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("rsp_seen", got, 1);
    chk("rsp_lat", lat, e_lat);
    chk("rsp_id", sysmap_rsp_id, gid);
    chk("rsp_region", sysmap_rsp_region, e_reg);
    chk("rsp_attr", sysmap_rsp_attr, e_at);
    dtlb_sysmap_req_vld = 1'b0;
    itlb_sysmap_req_vld = 1'b0;
    if (got && !resp_wr) begin
      mc_vld = 1'b1;
      mc_addr = a;
      mc_reg = e_reg;
      mc_attr = e_at;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          pat, wr_at;
    logic [27:0] last_a, ra, rb;
    cpurst = 1'b1;
    dtlb_sysmap_req_vld = 1'b1;
    itlb_sysmap_req_vld = 1'b1;
    dtlb_sysmap_req_addr = '0;
    itlb_sysmap_req_addr = '0;
    cp0_sysmap_wen = 1'b0;
    cp0_sysmap_idx = '0;
    cp0_sysmap_upaddr = '0;
    cp0_sysmap_attr = '0;
    model_reset();

    // Reset: requests present but never granted, no response.
    repeat (3) begin
      @(negedge forever_cpuclk);
      #1;
      chk("rst_rdy", {sysmap_dtlb_req_rdy, sysmap_itlb_req_rdy}, 32'd0);
      chk("rst_rsp_vld", sysmap_rsp_vld, 0);
    end
    @(negedge forever_cpuclk);
    cpurst = 1'b0;
    dtlb_sysmap_req_vld = 1'b0;
    itlb_sysmap_req_vld = 1'b0;
    #1;
    chk("rst_rsp_id", sysmap_rsp_id, 0);
    chk("rst_rsp_region", sysmap_rsp_region, 0);
    chk("rst_rsp_attr", sysmap_rsp_attr, 0);
    chk("idle_rdy", {sysmap_dtlb_req_rdy, sysmap_itlb_req_rdy}, 32'd0);

    // Empty table: miss at T+9, region 8, default attribute.
    run_req(1, 0, 28'h100, 28'h0, -1, 0, 28'h0, 5'd0);

    cfg_write(0, 28'h100, 5'd1);
    cfg_write(1, 28'h200, 5'd2);
    cfg_write(2, 28'h300, 5'd3);
    run_req(1, 0, 28'h250, 28'h0, -1, 0, 28'h0, 5'd0);

    // Both requesters valid back to back: grants alternate.
    for (int i = 0; i < 4; i++)
      run_req(1, 1, 28'(i * 'h100 + 'h40), 28'(i * 'h100 + 'h80), -1, 0, 28'h0, 5'd0);

    // Table write mid-scan restarts the lookup.
    run_req(1, 0, 28'h250, 28'h0, 2, 1, 28'h260, 5'd2);

    // Repeated address (cache hit when enabled), then a write forces a full scan.
    run_req(1, 0, 28'h250, 28'h0, -1, 0, 28'h0, 5'd0);
    run_req(1, 0, 28'h250, 28'h0, -1, 0, 28'h0, 5'd0);
    cfg_write(7, 28'h0, DFLT);
    run_req(1, 0, 28'h250, 28'h0, -1, 0, 28'h0, 5'd0);

    // Write in the acceptance cycle is visible; write during the response is not.
    run_req(0, 1, 28'h0, 28'h350, 0, 3, 28'h400, 5'd4);
    run_req(1, 0, 28'h120, 28'h0, 3, 0, 28'h100, 5'd1);

    last_a = 28'h120;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, 7)), 28'($urandom_range(0, 1023)), 5'($urandom_range(0, 31)));
      pat = int'($urandom_range(1, 3));
      wr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      ra = ($urandom_range(0, 2) == 0) ? last_a : 28'($urandom_range(0, 1100));
      rb = ($urandom_range(0, 2) == 0) ? last_a : 28'($urandom_range(0, 1100));
      last_a = ra;
      run_req(pat[0], pat[1], ra, rb, wr_at, int'($urandom_range(0, 7)),
              28'($urandom_range(0, 1023)), 5'($urandom_range(0, 31)));
    end

    // Reset in the middle of a scan discards the lookup.
    cfg_write(0, 28'h100, 5'd1);
    @(negedge forever_cpuclk);
    dtlb_sysmap_req_vld = 1'b1;
    dtlb_sysmap_req_addr = 28'h250;
    #1;
    chk("pre_rst_rdy", sysmap_dtlb_req_rdy, 1);
    @(negedge forever_cpuclk);
    dtlb_sysmap_req_vld = 1'b0;
    @(negedge forever_cpuclk);
    cpurst = 1'b1;
    dtlb_sysmap_req_vld = 1'b1;
    itlb_sysmap_req_vld = 1'b1;
    repeat (2) begin
      #1;
      chk("midrst_rdy", {sysmap_dtlb_req_rdy, sysmap_itlb_req_rdy}, 32'd0);
      chk("midrst_rsp_vld", sysmap_rsp_vld, 0);
      @(negedge forever_cpuclk);
    end
    dtlb_sysmap_req_vld = 1'b0;
    itlb_sysmap_req_vld = 1'b0;
    @(posedge forever_cpuclk);
    #1;
    cpurst = 1'b0;
    model_reset();
    // First cycle out of reset: both valid, DTLB granted, table empty again.
    run_req(1, 1, 28'h100, 28'h200, -1, 0, 28'h0, 5'd0);
    run_req(1, 1, 28'h100, 28'h200, -1, 0, 28'h0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ct_mmu_sysmap_scan_ctrl.md
# ct_mmu_sysmap_scan_ctrl

Sequencing and arbitration controller for the MMU system-map (sysmap) attribute lookup. It owns the per-region upper-bound and attribute registers and shares one region comparator between the DTLB and ITLB refill requesters. Each lookup walks the regions one per cycle and returns the first matching region and its attribute. It sits between the TLB refill paths and the sysmap configuration CSR write port.

## Interface
- REGION_NUM, 8: number of sysmap regions, scanned in index order 0..REGION_NUM-1.
- ADDR_W, 28: physical page-number width compared, PA[39:12].
- ATTR_W, 5: region attribute width.
- forever_cpuclk  in  1  core clock; only clock.
- cpurst  in  1  reset; synchronous and active-high.
- dtlb_sysmap_req_vld  in  1  DTLB lookup request.
- dtlb_sysmap_req_addr  in  ADDR_W  DTLB page number.
- sysmap_dtlb_req_rdy  out  1  DTLB request accepted this cycle.
- itlb_sysmap_req_vld  in  1  ITLB lookup request.
- itlb_sysmap_req_addr  in  ADDR_W  ITLB page number.
- sysmap_itlb_req_rdy  out  1  ITLB request accepted this cycle.
- sysmap_rsp_vld  out  1  one-cycle response pulse; no backpressure.
- sysmap_rsp_id  out  1  requester of the response: 0 = DTLB, 1 = ITLB.
- sysmap_rsp_region  out  4  index of the hit region; REGION_NUM on miss.
- sysmap_rsp_attr  out  ATTR_W  attribute of the hit region; SYSMAP_DFLT_ATTR on miss.
- cp0_sysmap_wen  in  1  region configuration write strobe.
- cp0_sysmap_idx  in  3  region index written.
- cp0_sysmap_upaddr  in  ADDR_W  new upper bound (exclusive).
- cp0_sysmap_attr  in  ATTR_W  new attribute.

## Operation
- Register file holds upaddr[i] and attr[i]. On reset, upaddr = 0 and attr = SYSMAP_DFLT_ATTR, so every lookup misses.
- A configuration write updates entry idx at the clock edge. It is accepted in any state.
- FSM has three states: IDLE, SCAN and RESP. Reset state is IDLE.
- IDLE: round-robin grant between valid requesters.
  - rdy is asserted combinationally to the granted requester only; a request is accepted when vld && rdy.
  - On acceptance: capture addr and id, set scan index to 0, go to SCAN.
  - The priority pointer flips to the other requester after every grant. Reset value of the pointer is DTLB.
  - With a single requester valid, that requester is granted regardless of the pointer.
- SCAN: one region per cycle. The comparator produces ls_top = addr < upaddr[idx].
  - Region idx hits when ge_bottom && ls_top. ge_bottom is 1 for idx 0, otherwise it is the registered !ls_top of idx-1.
  - Scan stops at the first hit. It ends as a miss after idx REGION_NUM-1.
  - Both outcomes go to RESP with the result registered.
- RESP: drive rsp_vld for one cycle, then go to IDLE. No request is accepted in SCAN or RESP.
- A configuration write during SCAN restarts the scan from idx 0 on the next cycle, so the lookup sees the new table.
- A configuration write during RESP does not alter the response already computed.
- A configuration write in the same cycle as acceptance is visible to the scan.
- rdy and rsp_vld are never asserted during reset. Reset mid-scan discards the lookup and produces no response.

## Timing
- Acceptance happens at cycle T. Region k is compared in cycle T+1+k.
- A hit at region k gives rsp_vld at T+2+k. A miss gives rsp_vld at T+1+REGION_NUM (T+9 with defaults).
- The earliest next acceptance is the cycle after rsp_vld.
- Output reset values: rdy = 0, rsp_vld = 0, rsp_id = 0, rsp_region = 0, rsp_attr = 0.

## Configuration
- Feature macro: MMU_SYSMAP_LAST_HIT_EN.
- Defined: a one-entry last-result cache holds valid, addr, region and attr.
  - An accepted request whose addr equals the cached addr skips SCAN; rsp_vld follows at T+1.
  - The cache is filled at each RESP that was not disturbed by a configuration write.
  - Any configuration write clears the cache valid bit, as does reset.
- Undefined: there is no cache and every lookup scans.

## Structure
- Package ct_mmu_sysmap_pkg holds:
  - the FSM state encoding (IDLE/SCAN/RESP);
  - SYSMAP_DFLT_ATTR = 5'b01111;
  - the SYSMAP_REGION_NUM and SYSMAP_ADDR_W constants.
- Sub-module ct_mmu_sysmap_cmp: the shared magnitude comparator (addr < upaddr) and the hit combine (ge_bottom && ls_top). It is instantiated once.

## Test plan
- Reset, then a DTLB request for addr 0x0000100 with all upaddr = 0 -> miss at T+9 with region 8, attr 5'b01111, id 0.
- upaddr[0..2] = 0x100/0x200/0x300 with attr 1/2/3, DTLB addr 0x250 -> region 2, attr 3, rsp_vld at T+4.
- DTLB and ITLB valid together for four back-to-back lookups -> grants alternate DTLB, ITLB, DTLB, ITLB; the other rdy stays 0.
- During the scan of addr 0x250, write upaddr[1] = 0x260 at T+2 -> the scan restarts; response is region 1, attr 2, rsp_vld at T+5.
- With MMU_SYSMAP_LAST_HIT_EN, the same addr 0x250 repeated -> second response at T+1. After any configuration write, the next identical request scans fully.
- Assert cpurst during SCAN -> no rsp_vld; FSM in IDLE and rdy available in the cycle after reset deasserts; pointer is DTLB.
